mux_step_sequencer: RTL

Time-multiplexed sequencer for the 128-channel to 70-capacitor selection network. It accepts one channel word plus a per-step switch vector and applies one shift step per clock. Each step consumes the lowest channel bit into the capacitor word, or inserts a 1. It returns the final capacitor word, the residual channel word and a consumed-channel count through a valid/ready handshake, so that results reach the capacitor driver stage directly downstream.

---
 rtl/mux_step_sequencer_pkg.sv | 15 +
 rtl/mux_step_sequencer_step.sv | 29 ++
 rtl/mux_step_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mux_step_sequencer_pkg.sv
// Shared widths, step count and FSM encoding for the 128-channel to 70-capacitor
// selection sequencer.
package mux_step_sequencer_pkg;

    localparam int CHANNEL_NUM_DEF   = 128;
    localparam int CAPACITOR_NUM_DEF = 70;
    localparam int STEP_NUM_DEF      = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_step_sequencer_step.sv
// One shift step of the selection network: either consume the lowest channel bit
// into the capacitor word (and 1-fill the channel word) or insert a 1.
import mux_step_sequencer_pkg::*;

module comb_logic_fundamental #(
    parameter int CHANNEL_NUM   = CHANNEL_NUM_DEF,
    parameter int CAPACITOR_NUM = CAPACITOR_NUM_DEF
) (
    input  logic [CHANNEL_NUM-1:0]   din_in,
    input  logic                     sw,
    input  logic [CAPACITOR_NUM-1:0] dout_in,
    output logic [CHANNEL_NUM-1:0]   din_out,
    output logic [CAPACITOR_NUM-1:0] dout_out
);

    // Single-step shift of both words, selected by the step switch
    always_comb begin
        din_out  = din_in;
        dout_out = dout_in;
        if (sw) begin
            dout_out = {din_in[0], dout_in[CAPACITOR_NUM-1:1]};
            din_out  = {1'b1, din_in[CHANNEL_NUM-1:1]};
        end else begin
            dout_out = {1'b1, dout_in[CAPACITOR_NUM-1:1]};
            din_out  = din_in;
        end
    end

endmodule

// File: rtl/mux_step_sequencer.sv
// Time-multiplexed sequencer: accepts a channel word and switch vector, runs
// STEP_NUM shift steps, then presents the capacitor word via valid/ready.
import mux_step_sequencer_pkg::*;

module mux_step_sequencer #(
    parameter int CHANNEL_NUM   = CHANNEL_NUM_DEF,
    parameter int CAPACITOR_NUM = CAPACITOR_NUM_DEF,
    parameter int STEP_NUM      = STEP_NUM_DEF,
    parameter int CNT_W         = $clog2(STEP_NUM + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [CHANNEL_NUM-1:0]   din,
    input  logic [STEP_NUM-1:0]      sw_vec,
    output logic [CAPACITOR_NUM-1:0] dout,
    output logic [CHANNEL_NUM-1:0]   din_rem,
    output logic [CNT_W-1:0]         sel_cnt,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     busy
);

    state_t                   state_r;
    state_t                   state_s;
    logic [CHANNEL_NUM-1:0]   din_r;
    logic [STEP_NUM-1:0]      sw_r;
    logic [CAPACITOR_NUM-1:0] dout_r;
    logic [CNT_W-1:0]         step_r;
    logic [CNT_W-1:0]         sel_cnt_r;
    logic [CHANNEL_NUM-1:0]   din_step_s;
    logic [CAPACITOR_NUM-1:0] dout_step_s;
    logic                     accept_s;
    logic                     step_last_s;

    assign accept_s    = start_valid && (state_r == ST_IDLE);
    assign step_last_s = (step_r == CNT_W'(STEP_NUM - 1));

    // sw_r is shifted right every step, so bit 0 always holds sw_vec[step]
    comb_logic_fundamental #(
        .CHANNEL_NUM   (CHANNEL_NUM),
        .CAPACITOR_NUM (CAPACITOR_NUM)
    ) u_step (
        .din_in   (din_r),
        .sw       (sw_r[0]),
        .dout_in  (dout_r),
        .din_out  (din_step_s),
        .dout_out (dout_step_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (step_last_s) state_s = ST_DONE;
                else             state_s = ST_RUN;
            end
            ST_DONE: begin
                if (dout_ready) state_s = ST_IDLE;
                else            state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode, from the state register only
    always_comb begin
        start_ready = 1'b0;
        dout_valid  = 1'b0;
        busy        = 1'b0;
        case (state_r)
            ST_IDLE: start_ready = 1'b1;
            ST_RUN:  busy        = 1'b1;
            ST_DONE: begin
                dout_valid = 1'b1;
                busy       = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    // Job datapath: load on accept, one shift step per RUN cycle, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_r     <= {CHANNEL_NUM{1'b1}};
            sw_r      <= {STEP_NUM{1'b0}};
            dout_r    <= {CAPACITOR_NUM{1'b1}};
            step_r    <= {CNT_W{1'b0}};
            sel_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        din_r     <= din;
                        sw_r      <= sw_vec;
                        dout_r    <= {CAPACITOR_NUM{1'b1}};
                        step_r    <= {CNT_W{1'b0}};
                        sel_cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    din_r     <= din_step_s;
                    dout_r    <= dout_step_s;
                    sw_r      <= {1'b0, sw_r[STEP_NUM-1:1]};
                    step_r    <= step_r + CNT_W'(1);
                    sel_cnt_r <= sel_cnt_r + {{(CNT_W-1){1'b0}}, sw_r[0]};
                end
                default: begin
                    din_r <= din_r;
                end
            endcase
        end
    end

    assign dout    = dout_r;
    assign din_rem = din_r;
    assign sel_cnt = sel_cnt_r;

endmodule
